cordic_atan2_mag: RTL and testbench
===================================

Name: cordic_atan2_mag

Overview:
Pipelined CORDIC in vectoring mode. Converts a Cartesian pair (x, y) into a polar angle atan2(y, x) in degrees and a magnitude sqrt(x²+y²).
It is the inverse companion of the rotation-mode sin/cos unit and uses the same Q16.16 degree format and the same atan table, so angles round-trip between the two blocks.
Fully pipelined: one result per clock, no backpressure.

Parameters:
PIPELINE, 16, number of micro-rotation stages; legal range 8..16 (atan table depth).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
x_in  in  32  signed Q16.16 x coordinate; |x_in| <= 2^28 required of source
y_in  in  32  signed Q16.16 y coordinate; |y_in| <= 2^28 required of source
pre_vaild  in  1  input sample valid, sampled every clk
angle  out  32  signed Q16.16 degrees, range (-180, +180]
mag  out  32  unsigned-valued signed Q16.16 magnitude, gain-corrected
post_vaild  out  1  angle/mag valid

Behaviour:
- Reset: angle=0, mag=0, post_vaild=0. All pipeline x/y/z registers and the valid shift register cleared asynchronously. The valid shift register is on the reset net, unlike the sin/cos unit.
- Stage M (map register, cycle 1):
  - If x_in<0: x0=-x_in, y0=-y_in, quad=1 (180° offset needed).
  - Else: x0=x_in, y0=y_in, quad=0.
  - z0=0.
  - zero flag = (x_in==0 && y_in==0).
  - quad and zero flag are carried alongside the data through the pipe.
- Stage i (1..PIPELINE), shift s=i-1:
  - If y[i-1]>=0 (sign bit 0): x += y>>>s; y -= x>>>s; z += ATAN[s].
  - Else: x -= y>>>s; y += x>>>s; z -= ATAN[s].
  - Arithmetic shifts only; all registers 32-bit signed.
  - The input range limit guarantees no overflow, since x growth is <= 2.33×.
- Output stage (cycle PIPELINE+2):
  - mag = (x[PIPELINE] × K) >>> 16, with K=0x09B74. Full 49-bit signed product, truncated.
  - angle:
    - quad=0: angle = z.
    - quad=1 and z<=0 (original y>=0): angle = z + DEG180.
    - quad=1 and z>0: angle = z − DEG180.
  - zero flag set: angle=0, mag=0 (CORDIC residue suppressed).
  - pre_vaild low at this stage: angle=0, mag=0.
- Latency: result for a sample accepted on edge N appears with post_vaild=1 after edge N+PIPELINE+2. Gaps in pre_vaild are preserved exactly; back-to-back valids give back-to-back results.
- x=0, y≠0: no special case. Converges to ±90°.
- x<0, y=0: angle = +180 (DEG180), never −180.
- Accuracy: angle within ±1311 LSB (0.02°); mag within ±64 LSB for |input| >= 1.0.
- Reset mid-stream: all in-flight samples are discarded, and post_vaild stays 0 until new samples traverse the full latency.

Decomposition:
- Package cordic_pkg: ATAN table (16 × 32-bit, 45° … 0.0018° scaled 2^16), K=0x09B74, DEG180=11796480, DEG90=5898240, Q16.16 width constant. The sin/cos unit is migrated to the same package.
- One sub-module, cordic_vec_stage: a single registered micro-rotation with parameter SHIFT, table constant input, and side-band quad/zero/valid passthrough. Instantiated PIPELINE times by generate.

Test Plan:
1. x=65536, y=65536 -> angle ≈ 2949120 (45°), mag ≈ 92682; post_vaild exactly PIPELINE+2 cycles after pre_vaild.
2. x=−65536, y=0 -> angle ≈ +11796480 (180°), mag ≈ 65536. Also x=−65536, y=−1 -> angle near −11796480.
3. x=0, y=−131072 -> angle ≈ −5898240 (−90°), mag ≈ 131072. Then x=0, y=0 -> angle=0, mag=0 exactly.
4. Sweep 360 points at radius 1000.0 driven back-to-back with pre_vaild=1. Each result must match atan2/hypot within tolerance, in order, with no gaps. Then loop the angles through the sin/cos unit and compare recovered x,y within ±0.1%.
5. pre_vaild pattern 1,0,0,1,1,0 -> identical post_vaild pattern delayed by PIPELINE+2; angle=mag=0 on invalid cycles.
6. Assert rst_n low mid-stream with 10 samples in flight -> all outputs 0 immediately. No post_vaild until PIPELINE+2 cycles after the first post-reset valid.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC sin/cos and atan2/magnitude units.
// Angles are Q16.16 degrees; both units must use this one atan table so angles round-trip.
package cordic_pkg;

  localparam int unsigned Q_W        = 32;
  localparam int unsigned ATAN_DEPTH = 16;

  typedef logic signed [Q_W-1:0] q16_t;

  localparam q16_t K_GAIN = 32'sh0000_9B74;
  localparam q16_t DEG180 = 32'sd11796480;
  localparam q16_t DEG90  = 32'sd5898240;

  // atan(2^-idx) in degrees, scaled by 2^16 and rounded
  function automatic q16_t atan_lut(input int unsigned idx);
    q16_t v;
    case (idx)
      0:       v = 32'sd2949120;
      1:       v = 32'sd1740967;
      2:       v = 32'sd919879;
      3:       v = 32'sd466945;
      4:       v = 32'sd234379;
      5:       v = 32'sd117304;
      6:       v = 32'sd58666;
      7:       v = 32'sd29335;
      8:       v = 32'sd14668;
      9:       v = 32'sd7334;
      10:      v = 32'sd3667;
      11:      v = 32'sd1833;
      12:      v = 32'sd917;
      13:      v = 32'sd458;
      14:      v = 32'sd229;
      15:      v = 32'sd115;
      default: v = 32'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered vectoring-mode micro-rotation: drives y toward zero and
// accumulates the rotated angle in z. Side-band flags ride along unchanged.
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int unsigned SHIFT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  q16_t i_x,
  input  q16_t i_y,
  input  q16_t i_z,
  input  q16_t i_atan,
  input  logic i_quad,
  input  logic i_zero,
  input  logic i_valid,
  output q16_t o_x,
  output q16_t o_y,
  output q16_t o_z,
  output logic o_quad,
  output logic o_zero,
  output logic o_valid
);

  q16_t w_xs;
  q16_t w_ys;
  q16_t r_x;
  q16_t r_y;
  q16_t r_z;
  logic r_quad;
  logic r_zero;
  logic r_valid;

  assign w_xs = i_x >>> SHIFT;
  assign w_ys = i_y >>> SHIFT;

  // Rotate against the sign of y so the vector converges onto the +x axis
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= 32'sd0;
      r_y     <= 32'sd0;
      r_z     <= 32'sd0;
      r_quad  <= 1'b0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (!i_y[Q_W-1]) begin
        r_x <= i_x + w_ys;
        r_y <= i_y - w_xs;
        r_z <= i_z + i_atan;
      end else begin
        r_x <= i_x - w_ys;
        r_y <= i_y + w_xs;
        r_z <= i_z - i_atan;
      end
      r_quad  <= i_quad;
      r_zero  <= i_zero;
      r_valid <= i_valid;
    end
  end

  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_z     = r_z;
  assign o_quad  = r_quad;
  assign o_zero  = r_zero;
  assign o_valid = r_valid;

endmodule

// File: rtl/cordic_atan2_mag.sv
// Pipelined vectoring CORDIC: (x, y) -> atan2 angle in Q16.16 degrees and
// gain-corrected magnitude. PIPELINE must stay within 8..16 (atan table depth).
module cordic_atan2_mag
  import cordic_pkg::*;
#(
  parameter int unsigned PIPELINE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic signed [31:0] x_in,
  input  logic signed [31:0] y_in,
  input  logic              pre_vaild,
  output logic signed [31:0] angle,
  output logic signed [31:0] mag,
  output logic              post_vaild
);

  q16_t r_map_x;
  q16_t r_map_y;
  logic r_map_quad;
  logic r_map_zero;
  logic r_map_valid;

  q16_t w_x     [0:PIPELINE];
  q16_t w_y     [0:PIPELINE];
  q16_t w_z     [0:PIPELINE];
  logic w_quad  [0:PIPELINE];
  logic w_zero  [0:PIPELINE];
  logic w_valid [0:PIPELINE];

  q16_t              w_zf;
  q16_t              w_angle;
  logic signed [48:0] w_prod;

  // Fold the left half-plane onto the right; the 180 deg offset is restored at the end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_map_x     <= 32'sd0;
      r_map_y     <= 32'sd0;
      r_map_quad  <= 1'b0;
      r_map_zero  <= 1'b0;
      r_map_valid <= 1'b0;
    end else begin
      if (x_in[31]) begin
        r_map_x    <= -x_in;
        r_map_y    <= -y_in;
        r_map_quad <= 1'b1;
      end else begin
        r_map_x    <= x_in;
        r_map_y    <= y_in;
        r_map_quad <= 1'b0;
      end
      r_map_zero  <= (x_in == 32'sd0) && (y_in == 32'sd0);
      r_map_valid <= pre_vaild;
    end
  end

  assign w_x[0]     = r_map_x;
  assign w_y[0]     = r_map_y;
  assign w_z[0]     = 32'sd0;
  assign w_quad[0]  = r_map_quad;
  assign w_zero[0]  = r_map_zero;
  assign w_valid[0] = r_map_valid;

  for (genvar g = 0; g < PIPELINE; g++) begin : g_stage
    cordic_vec_stage #(
      .SHIFT(g)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_x     (w_x[g]),
      .i_y     (w_y[g]),
      .i_z     (w_z[g]),
      .i_atan  (atan_lut(g)),
      .i_quad  (w_quad[g]),
      .i_zero  (w_zero[g]),
      .i_valid (w_valid[g]),
      .o_x     (w_x[g+1]),
      .o_y     (w_y[g+1]),
      .o_z     (w_z[g+1]),
      .o_quad  (w_quad[g+1]),
      .o_zero  (w_zero[g+1]),
      .o_valid (w_valid[g+1])
    );
  end

  assign w_zf   = w_z[PIPELINE];
  assign w_prod = 49'(w_x[PIPELINE]) * 49'(K_GAIN);

  // z <= 0 after folding means the original y was >= 0, so exactly 180 maps to +180
  always_comb begin
    w_angle = w_zf;
    if (w_quad[PIPELINE]) begin
      if (w_zf <= 32'sd0) begin
        w_angle = w_zf + DEG180;
      end else begin
        w_angle = w_zf - DEG180;
      end
    end else begin
      w_angle = w_zf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle      <= 32'sd0;
      mag        <= 32'sd0;
      post_vaild <= 1'b0;
    end else begin
      if (w_valid[PIPELINE] && !w_zero[PIPELINE]) begin
        angle <= w_angle;
        mag   <= 32'(w_prod >>> 16);
      end else begin
        angle <= 32'sd0;
        mag   <= 32'sd0;
      end
      post_vaild <= w_valid[PIPELINE];
    end
  end

endmodule

// File: tb/tb_cordic_atan2_mag.sv
// Bench for cordic_atan2_mag: real-valued atan2/hypot reference with a cycle-indexed
// history of driven samples; every cycle the outputs are compared against it.
module tb_cordic_atan2_mag;

  localparam int  P   = 16;
  localparam int  LAT = P + 2;
  localparam real PI  = 3.14159265358979323846;
  localparam real SC  = 65536.0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [31:0] x_in = 32'sd0;
  logic signed [31:0] y_in = 32'sd0;
  logic              pre_vaild = 1'b0;
  logic signed [31:0] angle;
  logic signed [31:0] mag;
  logic              post_vaild;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic hv [64];
  int   hx [64];
  int   hy [64];

  cordic_atan2_mag #(.PIPELINE(P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x_in       (x_in),
    .y_in       (y_in),
    .pre_vaild  (pre_vaild),
    .angle      (angle),
    .mag        (mag),
    .post_vaild (post_vaild)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real abs_r(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // Ideal atan2 in Q16.16 degrees
  function automatic real exp_angle(input int x, input int y);
    return $atan2(real'(y), real'(x)) * 180.0 / PI * SC;
  endfunction

  // CORDIC gain for P rotations times the fixed 0x9B74 correction factor
  function automatic real exp_mag(input int x, input int y);
    real g;
    g = 1.0;
    for (int i = 0; i < P; i++) g = g * $sqrt(1.0 + 1.0 / (4.0 ** i));
    return $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * g * 39796.0 / SC;
  endfunction

  function automatic real wrap_diff(input real a, input real b);
    real d;
    d = a - b;
    if (d > 180.0 * SC) d = d - 360.0 * SC;
    else if (d < -180.0 * SC) d = d + 360.0 * SC;
    return d;
  endfunction

  task automatic report(input string name, input bit ok, input longint act, input longint req);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Per-cycle compare of the DUT outputs against the delayed reference
  always @(negedge clk) begin
    logic ev;
    int   ex, ey;
    real  ea, em, r, rx, ry;
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) hv[i] <= 1'b0;
      report("reset_outputs", (angle == 0) && (mag == 0) && !post_vaild,
             {angle, mag}, 0);
    end else begin
      hv[cyc % 64] <= pre_vaild;
      hx[cyc % 64] <= x_in;
      hy[cyc % 64] <= y_in;
      ev = (cyc >= LAT) ? hv[(cyc - LAT) % 64] : 1'b0;
      ex = hx[(cyc - LAT + 64) % 64];
      ey = hy[(cyc - LAT + 64) % 64];
      report("post_vaild", post_vaild == ev, post_vaild, ev);
      if (!ev || (ex == 0 && ey == 0)) begin
        report("zero_out_angle", angle == 0, angle, 0);
        report("zero_out_mag", mag == 0, mag, 0);
      end else begin
        ea = exp_angle(ex, ey);
        em = exp_mag(ex, ey);
        report("angle", abs_r(wrap_diff(real'(angle), ea)) <= 1311.0, angle, longint'(ea));
        report("mag", abs_r(real'(mag) - em) <= 64.0, mag, longint'(em));
        r = $sqrt(real'(ex) * real'(ex) + real'(ey) * real'(ey));
        if (r >= 100.0 * SC) begin
          rx = real'(mag) * $cos(real'(angle) / SC * PI / 180.0);
          ry = real'(mag) * $sin(real'(angle) / SC * PI / 180.0);
          report("roundtrip_x", abs_r(rx - real'(ex)) <= 0.001 * r, longint'(rx), ex);
          report("roundtrip_y", abs_r(ry - real'(ey)) <= 0.001 * r, longint'(ry), ey);
        end
      end
    end
  end

  task automatic drive(input bit v, input int x, input int y);
    @(posedge clk);
    #1;
    pre_vaild = v;
    x_in      = x;
    y_in      = y;
  endtask

  // Single isolated sample: exact latency plus hand-computed expectations
  task automatic directed(input string name, input int x, input int y,
                          input longint a_lit, input longint a_tol,
                          input longint m_lit, input longint m_tol);
    int     k, lat;
    longint a, m;
    drive(1'b1, x, y);
    k = 0; lat = -1; a = 0; m = 0;
    while (lat < 0 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) begin
        pre_vaild = 1'b0; x_in = 32'sd0; y_in = 32'sd0;
      end
      if (post_vaild) begin
        lat = k; a = angle; m = mag;
      end
    end
    report({name, "_latency"}, lat == LAT, lat, LAT);
    report({name, "_angle"}, (a - a_lit <= a_tol) && (a_lit - a <= a_tol), a, a_lit);
    report({name, "_mag"}, (m - m_lit <= m_tol) && (m_lit - m <= m_tol), m, m_lit);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat [6];
    int x, y;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    report("model_45", longint'(exp_angle(65536, 65536)) == 64'sd2949120,
           longint'(exp_angle(65536, 65536)), 2949120);
    report("model_180", longint'(exp_angle(-65536, 0)) == 64'sd11796480,
           longint'(exp_angle(-65536, 0)), 11796480);
    report("model_mag", abs_r(exp_mag(65536, 0) - 65534.0) <= 1.0,
           longint'(exp_mag(65536, 0)), 65534);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    directed("diag45",   65536,  65536,  2949120, 1311, 92682, 64);
    directed("neg_x",   -65536,      0, 11796480, 1311, 65536, 64);
    directed("neg_y90",      0, -131072, -5898240, 1311, 131072, 64);
    directed("origin",       0,      0,        0,    0,      0,  0);

    drive(1'b1, -65536, -1);
    for (int k = 0; k < 360; k++) begin
      x = int'(1000.0 * SC * $cos(real'(k) * PI / 180.0));
      y = int'(1000.0 * SC * $sin(real'(k) * PI / 180.0));
      drive(1'b1, x, y);
    end
    for (int k = 0; k < 6; k++) drive(pat[k], 65536 * (k + 2), -40000 * k);
    repeat (LAT + 2) drive(1'b0, 0, 0);

    for (int k = 0; k < 400; k++) begin
      x = int'($urandom_range(0, 536870912)) - 268435456;
      y = int'($urandom_range(0, 536870912)) - 268435456;
      if (x < 65536 && x > -65536 && y < 65536 && y > -65536) x = 65536;
      if (k % 37 == 0) begin x = 0; y = 0; end
      if (k % 23 == 0) x = 0;
      drive($urandom_range(0, 3) != 0, x, y);
    end

    for (int k = 0; k < 10; k++) drive(1'b1, 65536 * (k + 1), 30000 * k);
    @(posedge clk);
    #1;
    rst_n = 1'b0; pre_vaild = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) drive(1'b1, -70000 * (k + 1), 12345 * k);
    repeat (LAT + 4) drive(1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
